// File: rtl/data_memory.sv
// Byte-addressable RV32 data memory: 32-bit word storage, a synchronous read-first load
// port with sign/zero extension, and a store port that merges byte/half/word lanes.
module data_memory #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       raddr,
    input  logic [31:0]       waddr,
    input  logic [DATA_W-1:0] din,
    input  logic [2:0]        MemOp,
    input  logic              MemWr,
    output logic [DATA_W-1:0] dout
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] ridx;
    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] rword;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q = '0;
    logic [3:0]        wbe;
    logic [DATA_W-1:0] wdata;
    logic              unused_addr;

    // Upper address bits alias the memory; they are deliberately dropped.
    assign ridx        = raddr[ADDR_W+1:2];
    assign widx        = waddr[ADDR_W+1:2];
    assign unused_addr = ^{raddr[31:ADDR_W+2], waddr[31:ADDR_W+2]};

    always_comb begin
        rword  = mem[ridx];
        rbyte  = rword[{raddr[1:0], 3'b000} +: 8];
        rhalf  = raddr[1] ? rword[31:16] : rword[15:0];
        dout_d = rword;
        case (MemOp)
            3'b000:  dout_d = {{24{rbyte[7]}}, rbyte};
            3'b001:  dout_d = {{16{rhalf[15]}}, rhalf};
            3'b100:  dout_d = {24'h000000, rbyte};
            3'b101:  dout_d = {16'h0000, rhalf};
            default: dout_d = rword;
        endcase
    end

    // Store data is replicated across lanes so each enabled lane takes din's low bits.
    always_comb begin
        wbe   = 4'b0000;
        wdata = din;
        case (MemOp)
            3'b000, 3'b100: begin
                wbe   = 4'b0001 << waddr[1:0];
                wdata = {4{din[7:0]}};
            end
            3'b001, 3'b101: begin
                wbe   = waddr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            3'b010:  wbe = 4'b1111;
            default: wbe = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && MemWr) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Reads sample the array before the same-edge write lands (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed load/store cases plus randomized traffic
// compared against a byte-array reference model.
module tb_data_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] din;
    logic [2:0]  MemOp;
    logic        MemWr;
    logic [31:0] dout;

    int errors = 0;
    int checks = 0;

    logic [7:0] bmem [0:131071];

    data_memory dut (
        .clk   (clk),
        .rst   (rst),
        .raddr (raddr),
        .waddr (waddr),
        .din   (din),
        .MemOp (MemOp),
        .MemWr (MemWr),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
        int b  = int'(a[16:0]);
        int wb = b - (b % 4);
        int hb = wb + (a[1] ? 2 : 0);
        logic [31:0] w  = {bmem[wb+3], bmem[wb+2], bmem[wb+1], bmem[wb]};
        logic [15:0] h  = {bmem[hb+1], bmem[hb]};
        logic [7:0]  by = bmem[b];
        case (op)
            3'b000:  return 32'(int'(by) - (by >= 8'd128 ? 256 : 0));
            3'b001:  return 32'(int'(h) - (h >= 16'h8000 ? 65536 : 0));
            3'b100:  return 32'(by);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        int b  = int'(a[16:0]);
        int wb = b - (b % 4);
        int hb = wb + (a[1] ? 2 : 0);
        case (op)
            3'b000, 3'b100: bmem[b] = d[7:0];
            3'b001, 3'b101: begin
                bmem[hb]   = d[7:0];
                bmem[hb+1] = d[15:8];
            end
            3'b010: begin
                bmem[wb]   = d[7:0];
                bmem[wb+1] = d[15:8];
                bmem[wb+2] = d[23:16];
                bmem[wb+3] = d[31:24];
            end
            default: ;
        endcase
    endtask

    task automatic bd_write(input int idx, input logic [31:0] val);
        dut.mem[idx] = val;
        bmem[4*idx]   = val[7:0];
        bmem[4*idx+1] = val[15:8];
        bmem[4*idx+2] = val[23:16];
        bmem[4*idx+3] = val[31:24];
    endtask

    // One clock: drive, compute model expectation (pre-write), edge, check, then commit store.
    task automatic cycle(input logic r, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] d, input logic [2:0] op, input logic we,
                         input string tag, output logic [31:0] obs);
        logic [31:0] exp;
        rst   = r;
        raddr = ra;
        waddr = wa;
        din   = d;
        MemOp = op;
        MemWr = we;
        exp   = r ? 32'h0 : model_load(ra, op);
        @(posedge clk);
        #1;
        obs = dout;
        check(tag, obs, exp);
        if (!r && we) model_store(wa, op, d);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        logic [31:0] d;

        rst = 1'b1; raddr = '0; waddr = '0; din = '0; MemOp = '0; MemWr = 1'b0;
        for (int i = 0; i < 32768; i++) bd_write(i, $urandom);
        #1;
        check("init", dout, 32'h0);

        cycle(1'b1, 32'h0, 32'h0, 32'h0, 3'b010, 1'b0, "rst0", obs);

        bd_write(32'h10, 32'h89AB_CDEF);
        cycle(1'b0, 32'h40, 32'h0, 32'h0, 3'b000, 1'b0, "lb40", obs); check("lb40k", obs, 32'hFFFF_FFEF);
        cycle(1'b0, 32'h41, 32'h0, 32'h0, 3'b000, 1'b0, "lb41", obs); check("lb41k", obs, 32'hFFFF_FFCD);
        cycle(1'b0, 32'h42, 32'h0, 32'h0, 3'b000, 1'b0, "lb42", obs); check("lb42k", obs, 32'hFFFF_FFAB);
        cycle(1'b0, 32'h43, 32'h0, 32'h0, 3'b000, 1'b0, "lb43", obs); check("lb43k", obs, 32'hFFFF_FF89);
        cycle(1'b0, 32'h40, 32'h0, 32'h0, 3'b100, 1'b0, "lbu40", obs); check("lbu40k", obs, 32'h0000_00EF);
        cycle(1'b0, 32'h41, 32'h0, 32'h0, 3'b100, 1'b0, "lbu41", obs); check("lbu41k", obs, 32'h0000_00CD);
        cycle(1'b0, 32'h42, 32'h0, 32'h0, 3'b100, 1'b0, "lbu42", obs); check("lbu42k", obs, 32'h0000_00AB);
        cycle(1'b0, 32'h43, 32'h0, 32'h0, 3'b100, 1'b0, "lbu43", obs); check("lbu43k", obs, 32'h0000_0089);
        cycle(1'b0, 32'h40, 32'h0, 32'h0, 3'b001, 1'b0, "lh40", obs); check("lh40k", obs, 32'hFFFF_CDEF);
        cycle(1'b0, 32'h42, 32'h0, 32'h0, 3'b001, 1'b0, "lh42", obs); check("lh42k", obs, 32'hFFFF_89AB);
        cycle(1'b0, 32'h43, 32'h0, 32'h0, 3'b101, 1'b0, "lhu43", obs); check("lhu43k", obs, 32'h0000_89AB);
        cycle(1'b0, 32'h41, 32'h0, 32'h0, 3'b010, 1'b0, "lw41", obs); check("lw41k", obs, 32'h89AB_CDEF);

        bd_write(32'h40, 32'h1122_3344);
        cycle(1'b0, 32'h100, 32'h102, 32'hDEAD_BEEF, 3'b001, 1'b1, "sh", obs); check("shrf", obs, 32'h0000_3344);
        cycle(1'b0, 32'h100, 32'h0, 32'h0, 3'b010, 1'b0, "lw_sh", obs); check("lw_shk", obs, 32'hBEEF_3344);
        cycle(1'b0, 32'h0, 32'h101, 32'h0000_00AA, 3'b000, 1'b1, "sb", obs);
        cycle(1'b0, 32'h100, 32'h0, 32'h0, 3'b010, 1'b0, "lw_sb", obs); check("lw_sbk", obs, 32'hBEEF_AA44);
        cycle(1'b0, 32'h0, 32'h100, 32'h5A5A_1234, 3'b010, 1'b1, "sw", obs);
        cycle(1'b0, 32'h100, 32'h0, 32'h0, 3'b010, 1'b0, "lw_sw", obs); check("lw_swk", obs, 32'h5A5A_1234);

        cycle(1'b0, 32'h0, 32'h8002_0004, 32'hCAFE_F00D, 3'b010, 1'b1, "swal", obs);
        cycle(1'b0, 32'h4, 32'h0, 32'h0, 3'b010, 1'b0, "lwal", obs); check("lwalk", obs, 32'hCAFE_F00D);
        cycle(1'b0, 32'hFFFE_0004, 32'h0, 32'h0, 3'b101, 1'b0, "lhual", obs); check("lhualk", obs, 32'h0000_F00D);

        bd_write(32'h80, 32'hA5A5_A5A5);
        cycle(1'b0, 32'h200, 32'h200, 32'h1234_5678, 3'b010, 1'b1, "coll", obs); check("collk", obs, 32'hA5A5_A5A5);
        cycle(1'b0, 32'h200, 32'h0, 32'h0, 3'b010, 1'b0, "collnx", obs); check("collnxk", obs, 32'h1234_5678);
        cycle(1'b0, 32'h200, 32'h200, 32'h0, 3'b011, 1'b1, "op011", obs); check("op011k", obs, 32'h1234_5678);
        cycle(1'b0, 32'h200, 32'h0, 32'h0, 3'b010, 1'b0, "op011nx", obs); check("op011nxk", obs, 32'h1234_5678);

        cycle(1'b1, 32'h200, 32'h200, 32'hFFFF_FFFF, 3'b010, 1'b1, "rstwr", obs); check("rstwrk", obs, 32'h0);
        cycle(1'b0, 32'h200, 32'h0, 32'h0, 3'b010, 1'b0, "rstnx", obs); check("rstnxk", obs, 32'h1234_5678);

        for (int it = 0; it < 10; it++) begin
            a = $urandom;
            d = $urandom;
            cycle(1'b0, a, 32'h0, 32'h0, 3'b101, 1'b0, "rnd_rd0", obs);
            cycle(1'b0, $urandom, a, d, 3'b001, 1'b1, "rnd_sh", obs);
            cycle(1'b0, a, 32'h0, 32'h0, 3'b101, 1'b0, "rnd_rd1", obs);
            check("rnd_lhu", obs, {16'h0000, d[15:0]});
        end

        for (int it = 0; it < 40; it++) begin
            cycle(($urandom_range(0, 9) == 0), $urandom, $urandom, $urandom,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd_mix", obs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
